// File: rtl/dma_ch_sched.sv
// dma_ch_sched: round-robin owner scheduler for the shared DMA engine, with a beat quantum and a one-cycle handoff gap.
module dma_ch_sched #(
  parameter int N_CHANNELS = 4,
  parameter int CHANNEL_W = $clog2(N_CHANNELS),
  parameter int QUANTUM = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [N_CHANNELS-1:0] ch_enable_i,
  input  logic [N_CHANNELS-1:0] req_i,
  input  logic                  beat_i,
  input  logic                  done_i,
  output logic [N_CHANNELS-1:0] gnt_o,
  output logic                  gnt_valid_o,
  output logic [CHANNEL_W-1:0]  gnt_id_o,
  output logic                  yield_o,
  output logic                  busy_o
);
  localparam int CNT_W = $clog2(QUANTUM + 1);
  typedef enum logic [1:0] {IDLE, OWN, RELEASE} state_t;
  state_t state, state_d;
  logic [CHANNEL_W-1:0] owner, owner_d, last, last_d, base, sel, idx;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic [N_CHANNELS-1:0] elig, owner_oh;
  logic found, others, expire;
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
      owner <= '0;
      last  <= CHANNEL_W'(N_CHANNELS - 1);
      cnt   <= '0;
    end else begin
      state <= state_d;
      owner <= owner_d;
      last  <= last_d;
      cnt   <= cnt_d;
    end
  end
  assign elig     = req_i & ch_enable_i;
  assign owner_oh = N_CHANNELS'(1) << owner;
  // In the handoff cycle the old owner becomes the new pointer immediately.
  assign base     = state == RELEASE ? owner : last;
  assign others   = |(elig & ~owner_oh);
  assign expire   = beat_i && cnt == CNT_W'(QUANTUM - 1);
  always_comb begin
    sel   = base;
    idx   = '0;
    found = 1'b0;
    for (int i = 1; i <= N_CHANNELS; i++) begin
      idx = CHANNEL_W'((int'(base) + i) % N_CHANNELS);
      if (!found && elig[idx]) begin
        sel   = idx;
        found = 1'b1;
      end
    end
  end
  always_comb begin
    state_d = state;
    owner_d = owner;
    last_d  = last;
    cnt_d   = cnt;
    yield_o = 1'b0;
    case (state)
      IDLE: begin
        cnt_d   = '0;
        state_d = found ? OWN : IDLE;
        owner_d = found ? sel : owner;
      end
      OWN: begin
        cnt_d = beat_i ? cnt + CNT_W'(1) : cnt;
        if (done_i || !ch_enable_i[owner]) state_d = RELEASE;
        else if (expire && others) begin
          state_d = RELEASE;
          yield_o = !rst_i;
        end else if (expire) cnt_d = '0;
      end
      RELEASE: begin
        cnt_d   = '0;
        last_d  = owner;
        state_d = found ? OWN : IDLE;
        owner_d = found ? sel : owner;
      end
      default: state_d = IDLE;
    endcase
  end
  assign gnt_o       = state == OWN ? owner_oh : '0;
  assign gnt_valid_o = state == OWN;
  assign gnt_id_o    = state == OWN ? owner : '0;
  assign busy_o      = state != IDLE;
endmodule

// File: tb/tb_dma_ch_sched.sv
// tb_dma_ch_sched: directed scenarios plus randomized run against a rule-level reference model.
module tb_dma_ch_sched;
  localparam int N = 4;
  localparam int Q = 16;
  logic clk_i = 1'b0, rst_i = 1'b1, beat_i = 1'b0, done_i = 1'b0;
  logic [N-1:0] ch_enable_i = '0, req_i = '0, gnt_o;
  logic gnt_valid_o, yield_o, busy_o;
  logic [1:0] gnt_id_o;
  int checks = 0, failures = 0;

  dma_ch_sched #(.N_CHANNELS(N), .CHANNEL_W(2), .QUANTUM(Q)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .ch_enable_i(ch_enable_i), .req_i(req_i),
    .beat_i(beat_i), .done_i(done_i), .gnt_o(gnt_o), .gnt_valid_o(gnt_valid_o),
    .gnt_id_o(gnt_id_o), .yield_o(yield_o), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    rst_i = 1'b1; req_i = '0; ch_enable_i = '0; beat_i = 1'b0; done_i = 1'b0;
    tick(); tick();
    rst_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_i = 1'b1; req_i = 4'hF; ch_enable_i = 4'hF; beat_i = 1'b1; done_i = 1'b0;
    tick(); tick();
    #1;
    checks++;
    if ({gnt_o, gnt_valid_o, gnt_id_o, yield_o, busy_o} !== 9'b0) begin
      failures++;
      $display("FAIL reset_outputs got=%b exp=0", {gnt_o, gnt_valid_o, gnt_id_o, yield_o, busy_o});
    end
    rst_i = 1'b0; req_i = '0; beat_i = 1'b0;
  endtask

  task automatic test_single();
    do_reset();
    req_i = 4'b0001; ch_enable_i = 4'hF;
    tick();
    checks++;
    if (gnt_o !== 4'b0001 || gnt_id_o !== 2'd0 || gnt_valid_o !== 1'b1 || busy_o !== 1'b1) begin
      failures++;
      $display("FAIL single_grant got gnt=%b id=%0d v=%b busy=%b exp gnt=0001 id=0 v=1 busy=1", gnt_o, gnt_id_o, gnt_valid_o, busy_o);
    end
    repeat (4) tick();
    done_i = 1'b1; req_i = '0;
    tick();
    done_i = 1'b0;
    checks++;
    if (gnt_o !== 4'b0 || busy_o !== 1'b1) begin
      failures++;
      $display("FAIL single_release got gnt=%b busy=%b exp gnt=0000 busy=1", gnt_o, busy_o);
    end
    tick();
    checks++;
    if (gnt_o !== 4'b0 || busy_o !== 1'b0) begin
      failures++;
      $display("FAIL single_idle got gnt=%b busy=%b exp gnt=0000 busy=0", gnt_o, busy_o);
    end
  endtask

  task automatic test_round_robin();
    int order[5] = '{0, 1, 2, 3, 0};
    do_reset();
    req_i = 4'hF; ch_enable_i = 4'hF;
    tick();
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (gnt_o !== 4'(1 << order[k]) || gnt_id_o !== 2'(order[k])) begin
        failures++;
        $display("FAIL rr_grant%0d got gnt=%b id=%0d exp id=%0d", k, gnt_o, gnt_id_o, order[k]);
      end
      tick();
      done_i = 1'b1;
      tick();
      done_i = 1'b0;
      checks++;
      if (gnt_o !== 4'b0) begin
        failures++;
        $display("FAIL rr_gap%0d got gnt=%b exp=0000", k, gnt_o);
      end
      tick();
    end
  endtask

  task automatic test_quantum();
    logic bad;
    do_reset();
    req_i = 4'b0011; ch_enable_i = 4'hF;
    tick();
    beat_i = 1'b1;
    for (int b = 1; b <= Q; b++) begin
      #1;
      checks++;
      if (yield_o !== (b == Q) || gnt_o !== 4'b0001) begin
        failures++;
        $display("FAIL quantum_beat%0d got yield=%b gnt=%b exp yield=%b gnt=0001", b, yield_o, gnt_o, b == Q);
      end
      tick();
    end
    beat_i = 1'b0;
    checks++;
    if (gnt_o !== 4'b0) begin
      failures++;
      $display("FAIL quantum_gap got gnt=%b exp=0000", gnt_o);
    end
    tick();
    checks++;
    if (gnt_o !== 4'b0010) begin
      failures++;
      $display("FAIL quantum_next got gnt=%b exp=0010", gnt_o);
    end
    do_reset();
    req_i = 4'b0001; ch_enable_i = 4'hF;
    tick();
    beat_i = 1'b1;
    bad = 1'b0;
    for (int b = 0; b < 40; b++) begin
      #1;
      if (yield_o !== 1'b0 || gnt_o !== 4'b0001) bad = 1'b1;
      tick();
    end
    beat_i = 1'b0;
    checks++;
    if (bad !== 1'b0) begin
      failures++;
      $display("FAIL quantum_solo_keep got violation=%b exp=0", bad);
    end
  endtask

  task automatic test_disable();
    logic bad;
    do_reset();
    req_i = 4'b0100; ch_enable_i = 4'hF;
    tick();
    checks++;
    if (gnt_o !== 4'b0100 || gnt_id_o !== 2'd2) begin
      failures++;
      $display("FAIL disable_grant got gnt=%b id=%0d exp gnt=0100 id=2", gnt_o, gnt_id_o);
    end
    ch_enable_i = 4'b1011;
    tick();
    checks++;
    if (gnt_o !== 4'b0 || yield_o !== 1'b0) begin
      failures++;
      $display("FAIL disable_abort got gnt=%b yield=%b exp gnt=0000 yield=0", gnt_o, yield_o);
    end
    bad = 1'b0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (gnt_o !== 4'b0) bad = 1'b1;
    end
    checks++;
    if (bad !== 1'b0) begin
      failures++;
      $display("FAIL disable_never got granted=%b exp=0", bad);
    end
    ch_enable_i = 4'hF;
    tick();
    checks++;
    if (gnt_o !== 4'b0100) begin
      failures++;
      $display("FAIL disable_reenable got gnt=%b exp=0100", gnt_o);
    end
  endtask

  task automatic test_done_beat();
    do_reset();
    req_i = 4'b0011; ch_enable_i = 4'hF;
    tick();
    beat_i = 1'b1;
    repeat (Q - 1) tick();
    done_i = 1'b1;
    #1;
    checks++;
    if (yield_o !== 1'b0) begin
      failures++;
      $display("FAIL done_beat_yield got=%b exp=0", yield_o);
    end
    tick();
    beat_i = 1'b0; done_i = 1'b0;
    checks++;
    if (gnt_o !== 4'b0 || busy_o !== 1'b1) begin
      failures++;
      $display("FAIL done_beat_release got gnt=%b busy=%b exp gnt=0000 busy=1", gnt_o, busy_o);
    end
    tick();
    checks++;
    if (gnt_o !== 4'b0010) begin
      failures++;
      $display("FAIL done_beat_next got gnt=%b exp=0010", gnt_o);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    req_i = 4'b1000; ch_enable_i = 4'hF;
    tick();
    beat_i = 1'b1;
    repeat (5) tick();
    rst_i = 1'b1;
    tick();
    checks++;
    if ({gnt_o, gnt_valid_o, gnt_id_o, yield_o, busy_o} !== 9'b0) begin
      failures++;
      $display("FAIL reset_mid got=%b exp=0", {gnt_o, gnt_valid_o, gnt_id_o, yield_o, busy_o});
    end
    rst_i = 1'b0; beat_i = 1'b0; req_i = 4'hF;
    tick();
    checks++;
    if (gnt_o !== 4'b0001) begin
      failures++;
      $display("FAIL reset_mid_first got gnt=%b exp=0001", gnt_o);
    end
  endtask

  function automatic int pick(logic [N-1:0] e, int from);
    for (int k = 1; k <= N; k++)
      if (((e >> ((from + k) % N)) & 4'd1) != 4'd0) return (from + k) % N;
    return -1;
  endfunction

  task automatic test_random();
    bit owning, handoff;
    int owner, last, beats, p, bad_cycles;
    logic [N-1:0] e;
    logic exp_yield;
    logic [8:0] exp_v;
    do_reset();
    owning = 0; handoff = 0; owner = 0; last = N - 1; beats = 0; bad_cycles = 0;
    for (int c = 0; c < 3000; c++) begin
      req_i = 4'($urandom_range(0, 15));
      ch_enable_i = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(0, 15)) : 4'hF;
      beat_i = $urandom_range(0, 3) != 0;
      done_i = $urandom_range(0, 39) == 0;
      rst_i = $urandom_range(0, 299) == 0;
      #1;
      e = req_i & ch_enable_i;
      exp_yield = owning && !rst_i && !done_i && ch_enable_i[owner] && beat_i &&
                  beats == Q - 1 && (e & ~4'(1 << owner)) != 4'b0;
      exp_v = {owning ? 4'(1 << owner) : 4'b0, owning, owning ? 2'(owner) : 2'b0, exp_yield, owning || handoff};
      checks++;
      if ({gnt_o, gnt_valid_o, gnt_id_o, yield_o, busy_o} !== exp_v) begin
        failures++;
        if (bad_cycles < 10) $display("FAIL random_cycle%0d got=%b exp=%b", c, {gnt_o, gnt_valid_o, gnt_id_o, yield_o, busy_o}, exp_v);
        bad_cycles++;
      end
      if (rst_i) begin
        owning = 0; handoff = 0; last = N - 1; beats = 0;
      end else if (owning) begin
        if (done_i || !ch_enable_i[owner] || exp_yield) begin
          owning = 0; handoff = 1;
        end else if (beat_i) beats = (beats + 1) % Q;
      end else begin
        if (handoff) last = owner;
        handoff = 0;
        p = pick(e, last);
        beats = 0;
        if (p >= 0) begin
          owning = 1; owner = p;
        end
      end
      tick();
    end
    rst_i = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_quantum();
    test_disable();
    test_done_beat();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
